// File: rtl/aes_pkg.sv
// Shared AES-128 constants, key-schedule state encoding and round constant lookup.
package aes_pkg;
  localparam int AES_NR = 10;
  localparam int RK_W   = 128;

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} ks_state_t;
  typedef logic [7:0] rcon_t;

  function automatic rcon_t rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;
  logic [7:0] sq;

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as the S-box requires
  always_comb begin
    sq  = in_byte;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock into storage, with a
// combinational read port for the inverse-round datapath.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int KEY_W = RK_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [KEY_W-1:0] KEY,
  input  logic [3:0]       RK_IDX,
  output logic [KEY_W-1:0] RK_OUT,
  output logic             BUSY,
  output logic             DONE
);
  if (NR != 10 || KEY_W != 128) begin : g_bad_cfg
    $error("aes_key_schedule supports AES-128 only (NR=10, KEY_W=128)");
  end

  ks_state_t               state_q, state_d;
  logic [3:0]              round_q, round_d;
  logic [NR:0][KEY_W-1:0]  rk_q, rk_d;

  logic [KEY_W-1:0] prev_rk;
  logic [KEY_W-1:0] next_rk;
  logic [31:0]      rot_w, sub_w, t_w;
  logic [31:0]      n0, n1, n2, n3;

  always_comb begin
    prev_rk = '0;
    for (int i = 1; i <= NR; i++)
      if (round_q == 4'(i)) prev_rk = rk_q[i-1];
  end

  assign rot_w = {prev_rk[23:0], prev_rk[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_w[8*b +: 8]),
      .out_byte (sub_w[8*b +: 8])
    );
  end

  assign t_w     = sub_w ^ {rcon(round_q), 24'h0};
  assign n0      = prev_rk[127:96] ^ t_w;
  assign n1      = prev_rk[95:64]  ^ n0;
  assign n2      = prev_rk[63:32]  ^ n1;
  assign n3      = prev_rk[31:0]   ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rk_d    = rk_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          rk_d[0] = KEY;
          round_d = 4'd1;
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        for (int i = 1; i <= NR; i++)
          if (round_q == 4'(i)) rk_d[i] = next_rk;
        round_d = round_q + 4'd1;
        if (round_q == 4'(NR)) state_d = S_DONE;
      end
      S_DONE: begin
        // leaving DONE needs START low, so every new run sees a fresh 0->1
        if (!START) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      round_q <= '0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rk_q    <= rk_d;
    end
  end

  always_comb begin
    RK_OUT = '0;
    for (int i = 0; i <= NR; i++)
      if (RK_IDX == 4'(i)) RK_OUT = rk_q[i];
  end

  assign BUSY = (state_q == S_EXPAND);
  assign DONE = (state_q == S_DONE);
endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule using FIPS-197 golden round keys.
module tb_aes_key_schedule;
  logic         CLK = 1'b0;
  logic         RESET;
  logic         START;
  logic [127:0] KEY;
  logic [3:0]   RK_IDX;
  logic [127:0] RK_OUT;
  logic         BUSY;
  logic         DONE;

  int n_chk = 0;
  int n_err = 0;
  logic [127:0] gold [0:10];
  logic [127:0] exp_q [$];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Z_RK1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_schedule dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .KEY    (KEY),
    .RK_IDX (RK_IDX),
    .RK_OUT (RK_OUT),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // queue the expectation when the index is driven, compare when the port settles
  task automatic rd(input int idx, input logic [127:0] exp);
    RK_IDX = 4'(idx);
    exp_q.push_back(exp);
    #1;
    chk($sformatf("rk%0d", idx), RK_OUT, exp_q.pop_front());
  endtask

  // START must already be driven; counts edges (incl. edge N) until DONE
  task automatic run_to_done(input string tag, input bit zero_key_mid, output int edges, output int busy_n);
    edges  = 0;
    busy_n = 0;
    while (!DONE && edges < 30) begin
      tick();
      edges++;
      if (BUSY) busy_n++;
      if (zero_key_mid && edges == 1) KEY = '0;
    end
    chk({tag, "_edges"}, 128'(edges), 128'd11);
    chk({tag, "_busy"}, 128'(busy_n), 128'd10);
  endtask

  initial begin
    int e, b, d_n;
    gold[0]  = FIPS_KEY;
    gold[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    gold[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    gold[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    gold[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    gold[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    gold[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    gold[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    gold[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    gold[9]  = 128'hac7766f319fadc2128d12941575c006e;
    gold[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    RESET = 1'b1; START = 1'b0; KEY = '0; RK_IDX = '0;
    tick(); tick();
    chk("rst_busy", 128'(BUSY), 128'd0);
    chk("rst_done", 128'(DONE), 128'd0);
    for (int i = 0; i < 11; i++) rd(i, 128'h0);
    RESET = 1'b0;
    tick();

    // T1/T2: FIPS key, KEY zeroed after capture
    KEY = FIPS_KEY; START = 1'b1;
    run_to_done("t1", 1'b1, e, b);
    chk("t1_done", 128'(DONE), 128'd1);
    for (int i = 10; i >= 0; i--) rd(i, gold[i]);
    rd(11, 128'h0);
    rd(15, 128'h0);

    // T6: hold START, no re-expansion
    d_n = 0; b = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (DONE) d_n++;
      if (BUSY) b++;
    end
    chk("t6_done_held", 128'(d_n), 128'd50);
    chk("t6_no_busy", 128'(b), 128'd0);
    rd(10, gold[10]);
    START = 1'b0;
    tick();
    chk("t6_idle_done", 128'(DONE), 128'd0);
    chk("t6_idle_busy", 128'(BUSY), 128'd0);
    rd(5, gold[5]);

    // T2 rerun with the zero key now on the bus
    START = 1'b1;
    run_to_done("t2", 1'b0, e, b);
    rd(0, 128'h0);
    rd(1, Z_RK1);
    rd(10, Z_RK10);
    START = 1'b0;
    tick();

    // T3: reset on the 5th EXPAND cycle
    KEY = FIPS_KEY; START = 1'b1;
    repeat (5) tick();
    chk("t3_busy_pre", 128'(BUSY), 128'd1);
    RESET = 1'b1; START = 1'b0;
    tick();
    chk("t3_busy", 128'(BUSY), 128'd0);
    chk("t3_done", 128'(DONE), 128'd0);
    for (int i = 0; i < 11; i++) rd(i, 128'h0);
    RESET = 1'b0;
    tick();

    // T4: single-cycle START pulse
    START = 1'b1;
    tick();
    START = 1'b0;
    b = BUSY ? 1 : 0;
    d_n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (BUSY) b++;
      if (DONE) d_n++;
    end
    chk("t4_busy_cycles", 128'(b), 128'd10);
    chk("t4_done_cycles", 128'(d_n), 128'd1);
    chk("t4_idle", 128'({BUSY, DONE}), 128'd0);
    rd(0, gold[0]);
    rd(10, gold[10]);

    // T6 restart after 0->1
    START = 1'b1;
    run_to_done("t6_restart", 1'b0, e, b);
    rd(4, gold[4]);
    START = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
